// File: rtl/uart_pkg.sv
// Shared defaults and sizing helpers for the UART receive FIFO slice.
package uart_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 8;

  // Pointer width for a FIFO of the given depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
  output logic [DATA_W-1:0]         rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: pointer/occupancy control, sticky error flags and a registered CPU interrupt.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_ferr,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [ptr_w(DEPTH):0]    count,
  input  logic                     int_en,
  output logic                     int0,
  output logic                     ovf,
  output logic                     ferr,
  input  logic                     clr_err
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head;
  logic              wr_req;
  logic              push;
  logic              pop;
  logic              ovf_set;
  logic              ferr_set;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
  always_comb begin
    wr_req   = rx_valid & ~rx_ferr;
    pop      = rd_en & ~empty;
    push     = wr_req & (~full | pop);
    ovf_set  = wr_req & full & ~pop;
    ferr_set = rx_valid & rx_ferr;
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_data <= head;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Error sets take priority over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      ferr <= 1'b0;
      int0 <= 1'b0;
    end else begin
      ovf  <= ovf_set  | (ovf  & ~clr_err);
      ferr <= ferr_set | (ferr & ~clr_err);
      int0 <= int_en & ~empty;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, hand-written corner sequences, random traffic vs a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [3:0]    count;
  logic          int_en;
  logic          int0;
  logic          ovf;
  logic          ferr;
  logic          clr_err;

  uart_rx_fifo #(
    .DATA_W (DW),
    .DEPTH  (DEP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .int_en   (int_en),
    .int0     (int0),
    .ovf      (ovf),
    .ferr     (ferr),
    .clr_err  (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: a bounded queue plus the observable registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic          m_int0;
  logic          m_ovf;
  logic          m_ferr;

  typedef struct {
    logic          v;
    logic          fe;
    logic [DW-1:0] d;
    logic          rd;
    logic          clr;
    logic [DW-1:0] e_rd;
    int unsigned   e_cnt;
    logic          e_ferr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd   = '0;
    m_int0 = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  // Apply one cycle of stimulus, advance the model, then compare every output.
  task automatic cyc(input logic v, input logic fe, input logic [DW-1:0] d,
                     input logic rd, input logic clr);
    logic was_empty;
    logic ovf_set;
    rx_valid = v;
    rx_ferr  = fe;
    rx_data  = d;
    rd_en    = rd;
    clr_err  = clr;
    was_empty = (q.size() == 0);
    ovf_set   = 1'b0;
    m_int0    = int_en && !was_empty;
    if (rd && !was_empty) m_rd = q.pop_front();
    if (v && !fe) begin
      if (q.size() < DEP) q.push_back(d);
      else ovf_set = 1'b1;
    end
    m_ovf  = ovf_set | (m_ovf & !clr);
    m_ferr = (v && fe) | (m_ferr & !clr);
    @(posedge clk);
    #1;
    chk("rd_data", 32'(rd_data), 32'(m_rd));
    chk("count",   32'(count),   32'(q.size()));
    chk("empty",   32'(empty),   32'(q.size() == 0));
    chk("full",    32'(full),    32'(q.size() == DEP));
    chk("int0",    32'(int0),    32'(m_int0));
    chk("ovf",     32'(ovf),     32'(m_ovf));
    chk("ferr",    32'(ferr),    32'(m_ferr));
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int unsigned pw;
    int unsigned pr;
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    rd_en    = 1'b0;
    int_en   = 1'b0;
    clr_err  = 1'b0;
    model_reset();

    #12;
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    chk("rst_count",   32'(count),   32'h0);
    chk("rst_empty",   32'(empty),   32'h1);
    chk("rst_full",    32'(full),    32'h0);
    chk("rst_int0",    32'(int0),    32'h0);
    chk("rst_ovf",     32'(ovf),     32'h0);
    chk("rst_ferr",    32'(ferr),    32'h0);
    rst = 1'b0;

    // Directed table: three writes then three pops, framing-error discard, empty read, clear.
    tbl[0] = '{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'hA3, 1'b0, 1'b0, 8'h00, 2, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 8'h0F, 1'b0, 1'b0, 8'h00, 3, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 2, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA3, 1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0F, 0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h0F, 0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0F, 0, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 8'h0F, 0, 1'b1};
    tbl[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h0F, 0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].v, tbl[i].fe, tbl[i].d, tbl[i].rd, tbl[i].clr);
      chk("t_rd_data", 32'(rd_data), 32'(tbl[i].e_rd));
      chk("t_count",   32'(count),   32'(tbl[i].e_cnt));
      chk("t_empty",   32'(empty),   32'(tbl[i].e_cnt == 0));
      chk("t_ferr",    32'(ferr),    32'(tbl[i].e_ferr));
    end

    // Overflow on the ninth write, pops return the first eight, clear drops ovf.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      if (i == 8) begin
        chk("ovf_full8", 32'(full), 32'h1);
        chk("ovf_pre",   32'(ovf),  32'h0);
      end
    end
    chk("ovf_set",   32'(ovf),   32'h1);
    chk("ovf_count", 32'(count), 32'h8);
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      chk("ovf_pop", 32'(rd_data), 32'(i));
    end
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf), 32'h0);

    // Simultaneous write and pop while full.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    chk("fullrw_count", 32'(count),   32'h8);
    chk("fullrw_ovf",   32'(ovf),     32'h0);
    chk("fullrw_rd",    32'(rd_data), 32'h10);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("fullrw_last", 32'(rd_data), 32'h77);

    // Write and read while empty: write wins, read ignored.
    cyc(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    chk("emptyrw_count", 32'(count),   32'h1);
    chk("emptyrw_rd",    32'(rd_data), 32'h77);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Interrupt follows empty by one cycle in both directions.
    int_en = 1'b1;
    cyc(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
    chk("int_e0", 32'(empty), 32'h0);
    chk("int_lo", 32'(int0),  32'h0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("int_hi", 32'(int0),  32'h1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("int_e1",   32'(empty), 32'h1);
    chk("int_hold", 32'(int0),  32'h1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("int_fall", 32'(int0),  32'h0);

    // Half-cycle reset in mid-operation discards stored characters immediately.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mrst_count", 32'(count), 32'h0);
    chk("mrst_empty", 32'(empty), 32'h1);
    chk("mrst_int0",  32'(int0),  32'h0);
    chk("mrst_rd",    32'(rd_data), 32'h0);
    #4 rst = 1'b0;
    model_reset();
    cyc(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("mrst_pop", 32'(rd_data), 32'h42);

    // Random traffic in write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 900; i++) begin
      case ((i / 100) % 3)
        0:       begin pw = 80; pr = 20; end
        1:       begin pw = 20; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      if ($urandom_range(0, 31) == 0) int_en = ~int_en;
      cyc($urandom_range(0, 99) < pw,
          $urandom_range(0, 7) == 0,
          8'($urandom),
          $urandom_range(0, 99) < pr,
          $urandom_range(0, 15) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
